uart_tx_sched: RTL and testbench



---
 rtl/uart_ctrl_pkg.sv | 34 +++
 rtl/uart_rr_arbiter.sv | 54 +++++
 rtl/uart_tx_sched.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: types and helpers for the shared UART transmit scheduler.
//   tx_state_e  - frame sequencer states
//   data_bits_e - cfg_data_bits encoding (5..8 data bits)
//   data_len()  - number of data bits for an encoding
//   data_mask() - mask selecting the transmitted data bits of a byte
//   DEF_BAUD_DIV - divisor loaded at reset (115200 baud from 100 MHz)
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_e;

  localparam int unsigned DEF_BAUD_DIV = 868;

  function automatic logic [3:0] data_len(input data_bits_e bits);
    return 4'd5 + {2'b00, bits};
  endfunction

  function automatic logic [7:0] data_mask(input data_bits_e bits);
    return 8'hFF >> (4'd8 - data_len(bits));
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   clk, rst   - clock, synchronous active-high reset
//   req        - per-requester request vector
//   enable     - arbitration window; grant is forced to zero outside it
//   grant      - one-hot grant, valid only while enable is high
//   grant_idx  - index of the winning requester (meaningful when |grant)
// The search starts at the pointer; after a grant the pointer moves to the
// requester just after the winner, so a lone requester wins every time.
module uart_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (enable && found) begin
      grant[grant_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (enable && found) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART tx line between NUM_REQ frame requesters.
//   clk, rst        - clock, synchronous active-high reset
//   req_valid       - per-requester frame request
//   req_data        - per-requester byte, slice i = [8i+7:8i]
//   req_ready       - one-hot, one-cycle accept pulse
//   cfg_baud_div    - clocks per bit (0 behaves as 1)
//   cfg_data_bits   - 00=5 .. 11=8 data bits
//   cfg_parity_en   - append parity bit
//   cfg_parity_odd  - 1=odd, 0=even parity
//   cfg_two_stop    - 1=two stop bits
//   tx              - serial line, idle high
//   busy            - frame in progress (first START through last STOP clock)
//   done            - pulse on the last clock of the final stop bit
//   grant_id        - requester owning the current frame
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is only offered while the line is
// free (IDLE) or in the done cycle, and the byte plus every cfg_* input is
// captured in that same cycle; nothing sampled later affects the frame.
// A req_valid still high after its accept is treated as a fresh request.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DIV_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [DIV_W-1:0]     cfg_baud_div,
  input  logic [1:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      grant_id
);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       len_q, len_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             two_stop_q, two_stop_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_en;
  logic               grant_any;
  logic               last_baud;
  logic               last_stop;
  logic [7:0]         sel_byte;
  data_bits_e         cfg_bits;

  assign cfg_bits  = data_bits_e'(cfg_data_bits);
  assign last_baud = (baud_q == div_q - DIV_W'(1));
  assign last_stop = (bit_q == {3'b000, two_stop_q});
  assign done      = (state_q == STOP) && last_baud && last_stop;
  // Arbitrate when idle, or in the done cycle so back-to-back frames have
  // no idle bit between them.
  assign arb_en    = !rst && ((state_q == IDLE) || done);
  assign grant_any = |arb_grant;
  assign sel_byte  = req_data[{arb_idx, 3'b000} +: 8];

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    div_d      = div_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    grant_id_d = grant_id_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
      end
      START: begin
        if (last_baud) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (last_baud) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == len_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      PARITY: begin
        if (last_baud) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (last_baud) begin
          baud_d = '0;
          if (last_stop) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // A grant overrides the STOP->IDLE step and snapshots the whole frame.
    if (grant_any) begin
      state_d    = START;
      baud_d     = '0;
      bit_d      = '0;
      shift_d    = sel_byte;
      div_d      = (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
      len_d      = data_len(cfg_bits);
      par_en_d   = cfg_parity_en;
      par_bit_d  = (^(sel_byte & data_mask(cfg_bits))) ^ cfg_parity_odd;
      two_stop_d = cfg_two_stop;
      grant_id_d = arb_idx;
    end
  end

  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = par_bit_q;
      default: tx = 1'b1;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign req_ready = arb_grant;
  assign grant_id  = grant_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      div_q      <= DIV_W'(DEF_BAUD_DIV);
      len_q      <= 4'd8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      grant_id_q <= grant_id_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched.
// A per-clock scoreboard holds {grant_id, done, tx} for every busy cycle,
// built from a small frame model when each request is driven.
module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int DIV_W   = 16;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [DIV_W-1:0]     cfg_baud_div;
  logic [1:0]           cfg_data_bits;
  logic                 cfg_parity_en;
  logic                 cfg_parity_odd;
  logic                 cfg_two_stop;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      grant_id;

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  typedef struct {
    int         gid;
    logic [7:0] data;
    int         div;
    logic [1:0] bits;
    bit         pen;
    bit         podd;
    bit         two;
    int         exp_clocks;
  } vec_t;

  vec_t vecs[7];

  uart_tx_sched #(
    .NUM_REQ (NUM_REQ),
    .DIV_W   (DIV_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .cfg_baud_div   (cfg_baud_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .tx             (tx),
    .busy           (busy),
    .done           (done),
    .grant_id       (grant_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Frame model: start, N data bits LSB first, optional parity, stop bit(s),
  // each held max(div,1) clocks; done only on the very last clock.
  function automatic void push_frame(input int gid, input logic [7:0] d,
                                     input int div, input logic [1:0] bits,
                                     input bit pen, input bit podd, input bit two);
    logic fb[$];
    int   eff;
    int   nb;
    logic p;
    logic last;
    eff = (div == 0) ? 1 : div;
    nb  = 5 + int'(bits);
    p   = podd;
    fb.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      fb.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pen) fb.push_back(p);
    fb.push_back(1'b1);
    if (two) fb.push_back(1'b1);
    for (int b = 0; b < fb.size(); b++) begin
      for (int c = 0; c < eff; c++) begin
        last = (b == fb.size() - 1) && (c == eff - 1);
        exp_q.push_back({ID_W'(gid), last, fb[b]});
      end
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst && busy) begin
      if (exp_q.size() == 0) begin
        check("stream_unexpected_busy", 32'(busy), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_gid_done_tx", 32'({grant_id, done, tx}), 32'(mon_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    mon_en    = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n;
    logic [NUM_REQ*8-1:0] rd;
    @(posedge clk); #1;
    cfg_baud_div   = DIV_W'(v.div);
    cfg_data_bits  = v.bits;
    cfg_parity_en  = v.pen;
    cfg_parity_odd = v.podd;
    cfg_two_stop   = v.two;
    rd = $urandom();
    rd[v.gid*8 +: 8] = v.data;
    req_data = rd;
    req_valid = '0;
    req_valid[v.gid] = 1'b1;
    push_frame(v.gid, v.data, v.div, v.bits, v.pen, v.podd, v.two);
    @(negedge clk);
    check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'd1 << v.gid);
    // Everything below changes after the grant and must not disturb the frame.
    @(posedge clk); #1;
    req_valid      = '0;
    cfg_baud_div   = 16'd8;
    cfg_data_bits  = 2'($urandom_range(0, 3));
    cfg_parity_en  = 1'($urandom_range(0, 1));
    cfg_parity_odd = 1'($urandom_range(0, 1));
    cfg_two_stop   = 1'($urandom_range(0, 1));
    req_data       = $urandom();
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check($sformatf("vec%0d_clocks", k), 32'(n), 32'(v.exp_clocks));
    @(negedge clk);
    check($sformatf("vec%0d_idle_busy", k), 32'(busy), 32'd0);
    check($sformatf("vec%0d_idle_tx", k), 32'(tx), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int grants;
    int dones;
    bit saw_done;
    int ord[5];

    ord = '{0, 1, 2, 3, 0};
    //            gid data   div bits   pen podd two clocks
    vecs[0] = '{0, 8'hA5, 4, 2'b11, 1'b0, 1'b0, 1'b0, 40};
    vecs[1] = '{1, 8'h41, 2, 2'b10, 1'b1, 1'b1, 1'b1, 22};
    vecs[2] = '{3, 8'h00, 0, 2'b11, 1'b0, 1'b0, 1'b0, 10};
    vecs[3] = '{2, 8'hFF, 3, 2'b00, 1'b1, 1'b0, 1'b0, 24};
    vecs[4] = '{0, 8'h5A, 1, 2'b01, 1'b0, 1'b0, 1'b1, 9};
    vecs[5] = '{1, 8'hC3, 5, 2'b11, 1'b1, 1'b0, 1'b1, 60};
    vecs[6] = '{2, 8'h3C, 2, 2'b11, 1'b1, 1'b1, 1'b0, 22};

    rst            = 1'b1;
    req_valid      = '1;
    req_data       = '0;
    cfg_baud_div   = 16'd4;
    cfg_data_bits  = 2'b11;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_two_stop   = 1'b0;

    // Reset state, with every requester asserting during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;
    mon_en    = 1'b1;

    // Table-driven single frames.
    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k], k);
    end

    // Back-to-back: requester 2 re-requests during its own final stop bit.
    wait_idle();
    @(posedge clk); #1;
    cfg_baud_div   = 16'd2;
    cfg_data_bits  = 2'b11;
    cfg_parity_en  = 1'b0;
    cfg_two_stop   = 1'b0;
    req_data       = 32'h0096_0000;
    req_valid      = 4'b0100;
    push_frame(2, 8'h96, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_first_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (18) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data  = 32'h003C_0000;
    push_frame(2, 8'h3C, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_no_early_ready", 32'(req_ready), 32'h0);
    check("b2b_no_early_done", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_ready_in_done", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("b2b_start_tx", 32'(tx), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("b2b_second_len", 32'(n), 32'd19);

    // Reset in the middle of DATA.
    wait_idle();
    @(posedge clk); #1;
    cfg_baud_div = 16'd4;
    req_data     = 32'h0000_F000;
    req_valid    = 4'b0010;
    push_frame(1, 8'hF0, 4, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_rst_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (13) @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_rst_quiet", 32'(saw_done), 32'd0);
    mon_en = 1'b1;
    // Pointer is back at 0, so requester 1 beats requester 3.
    @(posedge clk); #1;
    cfg_baud_div = 16'd1;
    req_data     = 32'h7700_5E00;
    req_valid    = 4'b1010;
    push_frame(1, 8'h5E, 1, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Fairness: all four held valid, five frames back to back.
    pulse_reset();
    @(posedge clk); #1;
    cfg_baud_div  = 16'd1;
    cfg_data_bits = 2'b11;
    cfg_parity_en = 1'b0;
    cfg_two_stop  = 1'b0;
    req_data      = 32'h4433_2211;
    req_valid     = 4'hF;
    for (int k = 0; k < 5; k++) begin
      push_frame(ord[k], 8'(8'h11 * (ord[k] + 1)), 1, 2'b11, 1'b0, 1'b0, 1'b0);
    end
    n      = 0;
    grants = 0;
    dones  = 0;
    while (dones < 5 && n < 1000) begin
      @(negedge clk);
      if (|req_ready) begin
        if (grants < 5) begin
          check($sformatf("rr_grant%0d", grants), 32'(req_ready), 32'd1 << ord[grants]);
        end else begin
          check("rr_extra_grant", 32'(req_ready), 32'd0);
        end
        grants++;
      end
      if (done) dones++;
      n++;
      @(posedge clk); #1;
      if (grants >= 5) req_valid = '0;
    end
    check("rr_total_clocks", 32'(n - 1), 32'd50);
    check("rr_grants", 32'(grants), 32'd5);
    wait_idle();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
